dbg_ocimem_ctrl: RTL and testbench

- Downstream consumer of the debug-slave sysclk command outputs (`jdo`, `take_action_ocimem_a/b`, `take_no_action_ocimem_a`).
- Executes JTAG monitor reads and writes on a small on-chip debug RAM with an auto-incrementing address.
- Returns `MonDReg`, `monitor_ready` and `monitor_error` to the debug-slave tck logic.
- Also gives the CPU an Avalon-MM slave port into the same RAM; JTAG has priority.

---
 rtl/dbg_ocimem_pkg.sv | 29 ++
 rtl/dbg_ocimem_ram.sv | 23 ++
 rtl/dbg_ocimem_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_dbg_ocimem_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_ocimem_pkg.sv
// Shared types and constants for the OCI debug-memory controller.
package dbg_ocimem_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_J_RD,
    S_J_CAP,
    S_J_WR,
    S_C_RD,
    S_C_CAP,
    S_C_WR
  } state_e;

  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_A,
    CMD_NA,
    CMD_B
  } cmd_e;

  localparam int unsigned ADDR_LD   = 35;
  localparam int unsigned RD_EN     = 34;
  localparam int unsigned ADDR_LSB  = 17;
  localparam int unsigned WDATA_MSB = 34;
  localparam int unsigned WDATA_LSB = 3;

  localparam logic [31:0] ERR_PATTERN = 32'hDEAD_DEAD;

endpackage

// File: rtl/dbg_ocimem_ram.sv
// Single-port synchronous debug RAM, DEPTH x 32, registered read (1-cycle latency).
module dbg_ocimem_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dbg_ocimem_ctrl.sv
// JTAG monitor access to the on-chip debug RAM plus an Avalon-MM CPU port (JTAG first).
// Define OCIMEM_RANGE_CHECK_EN to reject addresses >= DEPTH with ERR_PATTERN / monitor_error.
module dbg_ocimem_ctrl
  import dbg_ocimem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [31:0]       cpu_writedata,
  output logic [31:0]       cpu_readdata,
  output logic              cpu_waitrequest
);

  localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef OCIMEM_RANGE_CHECK_EN
  localparam bit RANGE_CHK = 1'b1;
`else
  localparam bit RANGE_CHK = 1'b0;
`endif
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

  function automatic logic out_of_range(input logic [ADDR_W-1:0] a);
    return RANGE_CHK && ({1'b0, a} >= DEPTH_X);
  endfunction

  state_e              state_q, state_d;
  logic                pend_valid_q, pend_valid_d;
  cmd_e                pend_cmd_q, pend_cmd_d;
  logic [37:0]         pend_jdo_q, pend_jdo_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                oor_q, oor_d;
  logic [31:0]         mondreg_q, mondreg_d;
  logic                ready_q, ready_d;
  logic                err_q, err_d;

  cmd_e                in_cmd, exec_cmd;
  logic [37:0]         exec_jdo;
  logic                idle, accept_direct, accept_pend, drop;
  logic                ram_we;
  logic [RAM_AW-1:0]   ram_addr;
  logic [31:0]         ram_wdata, ram_rdata;
  logic                unused_ok;

  dbg_ocimem_ram #(.DEPTH(DEPTH), .AW(RAM_AW)) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    in_cmd = CMD_NONE;
    if (take_action_ocimem_b)         in_cmd = CMD_B;
    else if (take_action_ocimem_a)    in_cmd = CMD_A;
    else if (take_no_action_ocimem_a) in_cmd = CMD_NA;
  end

  // An idle FSM with an empty pending slot executes the incoming command directly,
  // so the pending register only holds commands that arrive while busy.
  assign idle          = (state_q == S_IDLE);
  assign accept_direct = (in_cmd != CMD_NONE) && !pend_valid_q && idle;
  assign accept_pend   = (in_cmd != CMD_NONE) && !pend_valid_q && !idle;
  assign drop          = (in_cmd != CMD_NONE) && pend_valid_q;

  always_comb begin
    state_d      = state_q;
    pend_valid_d = pend_valid_q;
    pend_cmd_d   = pend_cmd_q;
    pend_jdo_d   = pend_jdo_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    oor_d        = oor_q;
    mondreg_d    = mondreg_q;
    ready_d      = ready_q;
    err_d        = err_q;
    ram_we       = 1'b0;
    ram_addr     = addr_q[RAM_AW-1:0];
    ram_wdata    = wdata_q;
    cpu_readdata = '0;
    exec_cmd     = CMD_NONE;
    exec_jdo     = jdo;

    if (accept_direct || accept_pend) ready_d = 1'b0;
    if (accept_pend) begin
      pend_valid_d = 1'b1;
      pend_cmd_d   = in_cmd;
      pend_jdo_d   = jdo;
    end

    if (idle) begin
      if (pend_valid_q) begin
        exec_cmd     = pend_cmd_q;
        exec_jdo     = pend_jdo_q;
        pend_valid_d = 1'b0;
      end else begin
        exec_cmd = in_cmd;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        unique case (exec_cmd)
          CMD_B: begin
            wdata_d = exec_jdo[WDATA_MSB:WDATA_LSB];
            state_d = S_J_WR;
          end
          CMD_A: begin
            if (exec_jdo[ADDR_LD]) addr_d = exec_jdo[ADDR_LSB +: ADDR_W];
            if (exec_jdo[RD_EN]) begin
              state_d = S_J_RD;
            end else begin
              ready_d = 1'b1;
              if (exec_jdo[ADDR_LD]) err_d = 1'b0;
            end
          end
          CMD_NA: state_d = S_J_RD;
          CMD_NONE: begin
            if (cpu_read)       state_d = S_C_RD;
            else if (cpu_write) state_d = S_C_WR;
          end
        endcase
      end
      S_J_RD: begin
        oor_d   = out_of_range(addr_q);
        state_d = S_J_CAP;
      end
      S_J_CAP: begin
        mondreg_d = oor_q ? ERR_PATTERN : ram_rdata;
        addr_d    = addr_q + 1'b1;
        if (!accept_pend) ready_d = 1'b1;
        if (oor_q) err_d = 1'b1;
        state_d   = S_IDLE;
      end
      S_J_WR: begin
        ram_we  = !out_of_range(addr_q);
        addr_d  = addr_q + 1'b1;
        if (!accept_pend) ready_d = 1'b1;
        if (out_of_range(addr_q)) err_d = 1'b1;
        state_d = S_IDLE;
      end
      S_C_RD: begin
        ram_addr = cpu_address[RAM_AW-1:0];
        oor_d    = out_of_range(cpu_address);
        state_d  = S_C_CAP;
      end
      S_C_CAP: begin
        cpu_readdata = oor_q ? ERR_PATTERN : ram_rdata;
        state_d      = S_IDLE;
      end
      S_C_WR: begin
        ram_addr  = cpu_address[RAM_AW-1:0];
        ram_wdata = cpu_writedata;
        ram_we    = !out_of_range(cpu_address);
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (drop) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pend_valid_q <= 1'b0;
      pend_cmd_q   <= CMD_NONE;
      pend_jdo_q   <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      oor_q        <= 1'b0;
      mondreg_q    <= '0;
      ready_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      pend_cmd_q   <= pend_cmd_d;
      pend_jdo_q   <= pend_jdo_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      oor_q        <= oor_d;
      mondreg_q    <= mondreg_d;
      ready_q      <= ready_d;
      err_q        <= err_d;
    end
  end

  assign MonDReg         = mondreg_q;
  assign monitor_ready   = ready_q;
  assign monitor_error   = err_q;
  assign cpu_waitrequest = (cpu_read || cpu_write) &&
                           !(state_q == S_C_CAP || state_q == S_C_WR);

  assign unused_ok = ^{exec_jdo[37:36], exec_jdo[2:0], cpu_address};

endmodule

// File: tb/tb_dbg_ocimem_ctrl.sv
// Directed self-checking bench for dbg_ocimem_ctrl (honours OCIMEM_RANGE_CHECK_EN).
module tb_dbg_ocimem_ctrl;

  localparam int ADDR_W = 8;
`ifdef OCIMEM_RANGE_CHECK_EN
  localparam int TB_DEPTH = 128;
  localparam bit RC = 1'b1;
`else
  localparam int TB_DEPTH = 256;
  localparam bit RC = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [37:0]       jdo = '0;
  logic              take_action_ocimem_a = 1'b0;
  logic              take_no_action_ocimem_a = 1'b0;
  logic              take_action_ocimem_b = 1'b0;
  logic [31:0]       MonDReg;
  logic              monitor_ready;
  logic              monitor_error;
  logic [ADDR_W-1:0] cpu_address = '0;
  logic              cpu_read = 1'b0;
  logic              cpu_write = 1'b0;
  logic [31:0]       cpu_writedata = '0;
  logic [31:0]       cpu_readdata;
  logic              cpu_waitrequest;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dbg_ocimem_ctrl #(.ADDR_W(ADDR_W), .DEPTH(TB_DEPTH)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error),
    .cpu_address             (cpu_address),
    .cpu_read                (cpu_read),
    .cpu_write               (cpu_write),
    .cpu_writedata           (cpu_writedata),
    .cpu_readdata            (cpu_readdata),
    .cpu_waitrequest         (cpu_waitrequest)
  );

  function automatic logic [37:0] mk_a(input logic ld, input logic rd, input logic [7:0] a);
    logic [37:0] j;
    j = '0;
    j[35] = ld;
    j[34] = rd;
    j[17 +: 8] = a;
    return j;
  endfunction

  function automatic logic [37:0] mk_b(input logic [31:0] d);
    logic [37:0] j;
    j = '0;
    j[34:3] = d;
    return j;
  endfunction

  // Called at a negedge; the pulse is sampled at the next posedge and the task returns one negedge later.
  task automatic pulse(input logic a, input logic na, input logic b, input logic [37:0] j);
    take_action_ocimem_a    = a;
    take_no_action_ocimem_a = na;
    take_action_ocimem_b    = b;
    jdo                     = j;
    @(negedge clk);
    take_action_ocimem_a    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b    = 1'b0;
    jdo                     = '0;
  endtask

  task automatic jwrite(input logic [31:0] d);
    pulse(1'b0, 1'b0, 1'b1, mk_b(d));
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checks++; if (MonDReg !== 32'h0) begin errors++; $display("FAIL reset_mondreg: got %h, expected %h", MonDReg, 32'h0); end
    checks++; if (monitor_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b, expected 0", monitor_ready); end
    checks++; if (monitor_error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b, expected 0", monitor_error); end
    checks++; if (cpu_readdata !== 32'h0) begin errors++; $display("FAIL reset_cpu_readdata: got %h, expected 0", cpu_readdata); end
    checks++; if (cpu_waitrequest !== 1'b0) begin errors++; $display("FAIL reset_waitrequest: got %b, expected 0", cpu_waitrequest); end
  endtask

  task automatic test_addr_load();
    pulse(1'b1, 1'b0, 1'b0, mk_a(1'b1, 1'b0, 8'h10));
    checks++; if (monitor_ready !== 1'b1) begin errors++; $display("FAIL addr_load_ready: got %b, expected 1", monitor_ready); end
  endtask

  task automatic test_write_read();
    logic [31:0] exp [3];
    exp[0] = 32'h1111_1111; exp[1] = 32'h2222_2222; exp[2] = 32'h3333_3333;
    for (int unsigned i = 0; i < 3; i++) begin
      pulse(1'b0, 1'b0, 1'b1, mk_b(exp[i]));
      checks++; if (monitor_ready !== 1'b0) begin errors++; $display("FAIL wr%0d_busy: ready got %b, expected 0", i, monitor_ready); end
      @(negedge clk);
      checks++; if (monitor_ready !== 1'b1) begin errors++; $display("FAIL wr%0d_done: ready got %b, expected 1", i, monitor_ready); end
    end
    for (int unsigned i = 0; i < 3; i++) begin
      if (i == 0) pulse(1'b1, 1'b0, 1'b0, mk_a(1'b1, 1'b1, 8'h10));
      else        pulse(1'b0, 1'b1, 1'b0, '0);
      checks++; if (monitor_ready !== 1'b0) begin errors++; $display("FAIL rd%0d_e0: ready got %b, expected 0", i, monitor_ready); end
      @(negedge clk);
      checks++; if (monitor_ready !== 1'b0) begin errors++; $display("FAIL rd%0d_e1: ready got %b, expected 0", i, monitor_ready); end
      @(negedge clk);
      checks++; if (monitor_ready !== 1'b1) begin errors++; $display("FAIL rd%0d_e2: ready got %b, expected 1", i, monitor_ready); end
      checks++; if (MonDReg !== exp[i]) begin errors++; $display("FAIL rd%0d_data: got %h, expected %h", i, MonDReg, exp[i]); end
    end
  endtask

  task automatic test_wrap();
    pulse(1'b1, 1'b0, 1'b0, mk_a(1'b1, 1'b0, 8'h00));
    jwrite(32'hA5A5_0001);
    pulse(1'b1, 1'b0, 1'b0, mk_a(1'b1, 1'b0, 8'hFF));
    jwrite(32'h5A5A_5A5A);
    checks++; if (monitor_error !== RC) begin errors++; $display("FAIL wrap_wr_err: got %b, expected %b", monitor_error, RC); end
    pulse(1'b0, 1'b1, 1'b0, '0);
    repeat (2) @(negedge clk);
    checks++; if (MonDReg !== 32'hA5A5_0001) begin errors++; $display("FAIL wrap_read0: got %h, expected %h", MonDReg, 32'hA5A5_0001); end
    pulse(1'b1, 1'b0, 1'b0, mk_a(1'b1, 1'b1, 8'hFF));
    repeat (2) @(negedge clk);
    checks++; if (MonDReg !== (RC ? 32'hDEAD_DEAD : 32'h5A5A_5A5A)) begin errors++; $display("FAIL wrap_readff: got %h, expected %h", MonDReg, (RC ? 32'hDEAD_DEAD : 32'h5A5A_5A5A)); end
    pulse(1'b1, 1'b0, 1'b0, mk_a(1'b1, 1'b0, 8'h00));
    checks++; if (monitor_error !== 1'b0) begin errors++; $display("FAIL wrap_err_clear: got %b, expected 0", monitor_error); end
  endtask

  task automatic test_cpu_priority();
    pulse(1'b1, 1'b0, 1'b0, mk_a(1'b1, 1'b0, 8'h20));
    jwrite(32'hCAFE_BABE);
    jwrite(32'h1234_5678);
    pulse(1'b1, 1'b0, 1'b0, mk_a(1'b1, 1'b0, 8'h21));
    cpu_address = 8'h20;
    cpu_read    = 1'b1;
    pulse(1'b0, 1'b1, 1'b0, '0);
    checks++; if (cpu_waitrequest !== 1'b1) begin errors++; $display("FAIL prio_wait_jrd: got %b, expected 1", cpu_waitrequest); end
    @(negedge clk);
    checks++; if (cpu_waitrequest !== 1'b1) begin errors++; $display("FAIL prio_wait_jcap: got %b, expected 1", cpu_waitrequest); end
    @(negedge clk);
    checks++; if (MonDReg !== 32'h1234_5678) begin errors++; $display("FAIL prio_jtag_data: got %h, expected %h", MonDReg, 32'h1234_5678); end
    checks++; if (cpu_waitrequest !== 1'b1) begin errors++; $display("FAIL prio_wait_idle: got %b, expected 1", cpu_waitrequest); end
    @(negedge clk);
    checks++; if (cpu_waitrequest !== 1'b1) begin errors++; $display("FAIL prio_wait_crd: got %b, expected 1", cpu_waitrequest); end
    @(negedge clk);
    checks++; if (cpu_waitrequest !== 1'b0) begin errors++; $display("FAIL prio_wait_ccap: got %b, expected 0", cpu_waitrequest); end
    checks++; if (cpu_readdata !== 32'hCAFE_BABE) begin errors++; $display("FAIL prio_cpu_data: got %h, expected %h", cpu_readdata, 32'hCAFE_BABE); end
    cpu_read = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_cpu_access();
    cpu_address   = 8'h30;
    cpu_writedata = 32'h0BAD_F00D;
    cpu_write     = 1'b1;
    #1;
    checks++; if (cpu_waitrequest !== 1'b1) begin errors++; $display("FAIL cpuwr_wait_idle: got %b, expected 1", cpu_waitrequest); end
    @(negedge clk);
    checks++; if (cpu_waitrequest !== 1'b0) begin errors++; $display("FAIL cpuwr_wait_cwr: got %b, expected 0", cpu_waitrequest); end
    cpu_write = 1'b0;
    @(negedge clk);
    cpu_read = 1'b1;
    @(negedge clk);
    checks++; if (cpu_waitrequest !== 1'b1) begin errors++; $display("FAIL cpurd_wait_crd: got %b, expected 1", cpu_waitrequest); end
    @(negedge clk);
    checks++; if (cpu_waitrequest !== 1'b0) begin errors++; $display("FAIL cpurd_wait_ccap: got %b, expected 0", cpu_waitrequest); end
    checks++; if (cpu_readdata !== 32'h0BAD_F00D) begin errors++; $display("FAIL cpurd_data: got %h, expected %h", cpu_readdata, 32'h0BAD_F00D); end
    cpu_read = 1'b0;
    @(negedge clk);
    pulse(1'b1, 1'b0, 1'b0, mk_a(1'b1, 1'b1, 8'h30));
    repeat (2) @(negedge clk);
    checks++; if (MonDReg !== 32'h0BAD_F00D) begin errors++; $display("FAIL cpuwr_jtag_readback: got %h, expected %h", MonDReg, 32'h0BAD_F00D); end
  endtask

  task automatic test_same_cycle();
    logic [37:0] j;
    pulse(1'b1, 1'b0, 1'b0, mk_a(1'b1, 1'b0, 8'h41));
    jwrite(32'h4141_4141);
    pulse(1'b1, 1'b0, 1'b0, mk_a(1'b1, 1'b0, 8'h40));
    j = mk_b(32'h0014_0077);
    j[35] = 1'b1;
    pulse(1'b1, 1'b0, 1'b1, j);
    @(negedge clk);
    checks++; if (monitor_ready !== 1'b1) begin errors++; $display("FAIL same_wr_ready: got %b, expected 1", monitor_ready); end
    pulse(1'b0, 1'b1, 1'b0, '0);
    repeat (2) @(negedge clk);
    checks++; if (MonDReg !== 32'h4141_4141) begin errors++; $display("FAIL same_addr_next: got %h, expected %h", MonDReg, 32'h4141_4141); end
    pulse(1'b1, 1'b0, 1'b0, mk_a(1'b1, 1'b1, 8'h40));
    repeat (2) @(negedge clk);
    checks++; if (MonDReg !== 32'h0014_0077) begin errors++; $display("FAIL same_wr_data: got %h, expected %h", MonDReg, 32'h0014_0077); end
    checks++; if (monitor_error !== 1'b0) begin errors++; $display("FAIL same_no_err: got %b, expected 0", monitor_error); end
  endtask

  task automatic test_overflow();
    pulse(1'b0, 1'b1, 1'b0, '0);
    checks++; if (monitor_error !== 1'b0) begin errors++; $display("FAIL ovf_first: err got %b, expected 0", monitor_error); end
    pulse(1'b0, 1'b1, 1'b0, '0);
    checks++; if (monitor_error !== 1'b0) begin errors++; $display("FAIL ovf_pending: err got %b, expected 0", monitor_error); end
    pulse(1'b0, 1'b1, 1'b0, '0);
    checks++; if (monitor_error !== 1'b1) begin errors++; $display("FAIL ovf_set: err got %b, expected 1", monitor_error); end
    repeat (4) @(negedge clk);
    checks++; if (monitor_error !== 1'b1) begin errors++; $display("FAIL ovf_sticky: err got %b, expected 1", monitor_error); end
    checks++; if (monitor_ready !== 1'b1) begin errors++; $display("FAIL ovf_drain_ready: got %b, expected 1", monitor_ready); end
    pulse(1'b1, 1'b0, 1'b0, mk_a(1'b1, 1'b0, 8'h10));
    checks++; if (monitor_error !== 1'b0) begin errors++; $display("FAIL ovf_clear: err got %b, expected 0", monitor_error); end
  endtask

`ifdef OCIMEM_RANGE_CHECK_EN
  task automatic test_range();
    pulse(1'b1, 1'b0, 1'b0, mk_a(1'b1, 1'b1, 8'h90));
    repeat (2) @(negedge clk);
    checks++; if (MonDReg !== 32'hDEAD_DEAD) begin errors++; $display("FAIL range_jtag_data: got %h, expected %h", MonDReg, 32'hDEAD_DEAD); end
    checks++; if (monitor_error !== 1'b1) begin errors++; $display("FAIL range_jtag_err: got %b, expected 1", monitor_error); end
    cpu_address = 8'h90;
    cpu_read    = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (cpu_readdata !== 32'hDEAD_DEAD) begin errors++; $display("FAIL range_cpu_data: got %h, expected %h", cpu_readdata, 32'hDEAD_DEAD); end
    cpu_read = 1'b0;
    @(negedge clk);
    pulse(1'b1, 1'b0, 1'b0, mk_a(1'b1, 1'b0, 8'h00));
  endtask
`endif

  task automatic test_reset_mid();
    pulse(1'b0, 1'b1, 1'b0, '0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (MonDReg !== 32'h0) begin errors++; $display("FAIL rstmid_mondreg: got %h, expected 0", MonDReg); end
    checks++; if (monitor_ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready: got %b, expected 0", monitor_ready); end
    repeat (2) @(negedge clk);
    checks++; if (MonDReg !== 32'h0) begin errors++; $display("FAIL rstmid_idle: got %h, expected 0", MonDReg); end
    pulse(1'b0, 1'b1, 1'b0, '0);
    repeat (2) @(negedge clk);
    checks++; if (MonDReg !== 32'hA5A5_0001) begin errors++; $display("FAIL rstmid_ram_kept: got %h, expected %h", MonDReg, 32'hA5A5_0001); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_addr_load();
    test_write_read();
    test_wrap();
    test_cpu_priority();
    test_cpu_access();
    test_same_cycle();
    test_overflow();
`ifdef OCIMEM_RANGE_CHECK_EN
    test_range();
`endif
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
